// File: rtl/ahb3lite_sram_ws_if.sv
// AHB3-Lite slave-side bus bundle for ahb3lite_sram_ws.
// Signals: HSEL/HADDR/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HWDATA/HREADY come
// from the master side. HRDATA/HREADYOUT/HRESP come back from the slave.
// HREADY is the bus-wide ready, which the interconnect drives. In a
// single-slave system it is simply HREADYOUT fed back.
interface ahb3lite_sram_ws_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave with a configurable number of wait states.
// Ports:
//   HCLK    - single clock; all state changes happen on its rising edge
//   HRESETn - asynchronous active-low reset
//   bus     - AHB slave bundle (ahb3lite_sram_ws_if.slave)
// Behaviour:
//   - An OKAY data phase takes WAIT_STATES cycles with HREADYOUT=0, then one
//     DATA cycle.
//   - An error takes two cycles: ERR1 then ERR2. Wait states never apply to it.
//   - A write commits at the clock edge that ends DATA, using byte-lane enables.
//   - Reads drive the full addressed word during DATA and 0 at all other times.
module ahb3lite_sram_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb3lite_sram_ws_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;        // bytes per word
  localparam int BW = $clog2(NB);            // byte-offset bits
  localparam int AW = $clog2(DEPTH);         // word-index bits
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH * NB);

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t                state, state_d;
  logic [2:0]            wcnt, wcnt_d;
  logic [AW-1:0]         a_idx;
  logic                  a_wr;
  logic [NB-1:0]         a_be;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  take, bad;
  logic [NB-1:0]         be;
  logic [31:0]           lane_off;

  // A new address phase is only taken while the previous data phase is
  // finishing, or while nothing is in flight.
  assign take = (state inside {IDLE, DATA, ERR2}) && bus.HSEL && bus.HREADY &&
                bus.HTRANS[1];

  always_comb begin
    bad = ({1'b0, bus.HADDR} >= MEM_BYTES) ||
          (bus.HSIZE > 3'(BW)) ||
          ((bus.HADDR & ((32'd1 << bus.HSIZE) - 32'd1)) != 32'd0);
    // A lane is enabled when it falls in the same naturally aligned
    // 2^HSIZE-byte block as the address (little-endian).
    lane_off = 32'(bus.HADDR[BW-1:0]);
    be       = '0;
    for (int i = 0; i < NB; i++)
      be[i] = ((32'(i) >> bus.HSIZE) == (lane_off >> bus.HSIZE));
  end

  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    case (state)
      WAIT: begin
        if (wcnt <= 3'd1) state_d = DATA;
        if (wcnt != 3'd0) wcnt_d = wcnt - 3'd1;
      end
      ERR1: state_d = ERR2;
      default: begin
        if (!take)                state_d = IDLE;
        else if (bad)             state_d = ERR1;
        else if (WAIT_STATES > 0) begin
          state_d = WAIT;
          wcnt_d  = 3'(WAIT_STATES);
        end
        else                      state_d = DATA;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
    end
  end

  // These registers are only read while a transfer is in flight, so they
  // have no reset.
  always_ff @(posedge HCLK) begin
    if (take) begin
      a_idx <= bus.HADDR[BW+AW-1:BW];
      a_wr  <= bus.HWRITE;
      a_be  <= be;
    end
  end

  // Reset forces IDLE asynchronously, so an abandoned write never commits.
  always_ff @(posedge HCLK) begin
    if (state == DATA && a_wr)
      for (int i = 0; i < NB; i++)
        if (a_be[i]) mem[a_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
  end

  assign bus.HREADYOUT = !(state inside {WAIT, ERR1});
  assign bus.HRESP     = state inside {ERR1, ERR2};
  assign bus.HRDATA    = (state == DATA && !a_wr) ? mem[a_idx] : '0;

  logic unused;
  assign unused = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};
endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Self-checking bench for ahb3lite_sram_ws.
// Three instances share one clock: WAIT_STATES = 0, 3 and 5. Only the
// currently selected instance sees HSEL. A pipelined master replays an op
// queue against a byte-level memory model. The expected ready, response and
// read data for every cycle are derived from the transfer rules.
module tb_ahb3lite_sram_ws;
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          act;
    bit          hsel;
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  int          sel;
  logic        m_hsel, m_hwrite;
  logic [31:0] m_haddr, m_hwdata;
  logic [2:0]  m_hsize, m_hburst;
  logic [3:0]  m_hprot;
  logic [1:0]  m_htrans;
  logic        o_rdy   [3];
  logic        o_resp  [3];
  logic [31:0] o_rdata [3];

  ahb3lite_sram_ws_if #(.DATA_WIDTH(32)) bi [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WSG = (g == 0) ? 0 : (g == 1) ? 3 : 5;
    assign bi[g].HSEL   = m_hsel && (sel == g);
    assign bi[g].HADDR  = m_haddr;
    assign bi[g].HWDATA = m_hwdata;
    assign bi[g].HWRITE = m_hwrite;
    assign bi[g].HSIZE  = m_hsize;
    assign bi[g].HBURST = m_hburst;
    assign bi[g].HPROT  = m_hprot;
    assign bi[g].HTRANS = m_htrans;
    assign bi[g].HREADY = bi[g].HREADYOUT;
    assign o_rdy[g]     = bi[g].HREADYOUT;
    assign o_resp[g]    = bi[g].HRESP;
    assign o_rdata[g]   = bi[g].HRDATA;
    ahb3lite_sram_ws #(.DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(WSG)) u_dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bi[g])
    );
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  rmem [3][1024];
  op_t         ops [$];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 5;
  endfunction

  // 256 words x 4 bytes = 1024 bytes; size at most a word; natural alignment
  function automatic bit is_err(input op_t o);
    return (o.addr >= 32'd1024) || (o.size > 3'd2) ||
           ((o.addr % (32'd1 << o.size)) != 32'd0);
  endfunction

  function automatic logic [31:0] rword(input int k, input logic [31:0] a);
    int w;
    w = int'(a & ~32'd3);
    return {rmem[k][w+3], rmem[k][w+2], rmem[k][w+1], rmem[k][w]};
  endfunction

  task automatic commit(input int k, input op_t o);
    int b;
    for (int j = 0; j < (1 << o.size); j++) begin
      b = int'(o.addr) + j;
      rmem[k][b] = o.wdata[8*(b%4) +: 8];
    end
  endtask

  task automatic push(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d);
    op_t o;
    o.act   = 1'b1;
    o.hsel  = 1'b1;
    o.trans = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
    o.wr    = wr;
    o.addr  = a;
    o.size  = sz;
    o.wdata = d;
    ops.push_back(o);
  endtask

  // HSEL=0 with any HTRANS, or HSEL=1 with IDLE/BUSY: nothing is captured
  task automatic push_idle();
    op_t o;
    o.act   = 1'b0;
    o.hsel  = 1'($urandom_range(0, 1));
    o.trans = o.hsel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
    o.wr    = 1'($urandom_range(0, 1));
    o.addr  = $urandom;
    o.size  = 3'($urandom_range(0, 2));
    o.wdata = $urandom;
    ops.push_back(o);
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      int          r;
      logic [2:0]  sz;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      if (r < 15) push_idle();
      else if (r < 27) begin
        case ($urandom_range(0, 2))
          0: begin sz = 3'd2; a = ($urandom | 32'h400) & ~32'd3; end
          1: begin sz = 3'($urandom_range(1, 2)); a = 32'($urandom_range(0, 255)) | 32'd1; end
          default: begin sz = 3'($urandom_range(3, 7)); a = 32'($urandom_range(0, 63)) << 2; end
        endcase
        push(1'($urandom_range(0, 1)), a, sz, $urandom);
      end else begin
        sz = 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
        push(1'($urandom_range(0, 1)), a, sz, $urandom);
      end
    end
  endtask

  // Pipelined master: the address of 'ap' overlaps the data phase of 'dp'.
  // The bench advances on the ready it expects, so it always terminates.
  task automatic run_ops(input int k);
    op_t         ap, dp;
    bit          ap_v, dp_v, dp_err, e_rdy, e_resp, ck_rd;
    int          dpc, ws;
    logic [31:0] e_rd;
    ap = '{default: '0};
    dp = '{default: '0};
    ws = ws_of(k);
    sel = k;
    ap_v = 0; dp_v = 0; dp_err = 0; dpc = 0;
    if (ops.size() > 0) begin ap = ops.pop_front(); ap_v = 1; end
    while (ap_v || dp_v) begin
      @(negedge HCLK);
      m_hsel   = ap_v ? ap.hsel : 1'b0;
      m_htrans = ap_v ? ap.trans : 2'b00;
      m_haddr  = ap.addr;
      m_hwrite = ap.wr;
      m_hsize  = ap.size;
      m_hburst = 3'($urandom_range(0, 7));
      m_hprot  = 4'($urandom_range(0, 15));
      m_hwdata = dp_v ? dp.wdata : $urandom;
      e_rd = '0;
      ck_rd = 1;
      if (!dp_v) begin e_rdy = 1; e_resp = 0; end
      else if (dp_err) begin e_rdy = (dpc != 0); e_resp = 1; end
      else if (dpc < ws) begin e_rdy = 0; e_resp = 0; end
      else begin
        e_rdy = 1; e_resp = 0;
        if (dp.wr) ck_rd = 0;
        else e_rd = rword(k, dp.addr);
      end
      chk($sformatf("hreadyout[%0d] a=%h", k, dp.addr), 32'(o_rdy[k]), 32'(e_rdy));
      chk($sformatf("hresp[%0d] a=%h", k, dp.addr), 32'(o_resp[k]), 32'(e_resp));
      if (ck_rd) chk($sformatf("hrdata[%0d] a=%h", k, dp.addr), o_rdata[k], e_rd);
      if (dp_v && !dp_err && !dp.wr && e_rdy) last_rd = o_rdata[k];
      if (e_rdy) begin
        if (dp_v && !dp_err && dp.wr) commit(k, dp);
        dp_v   = ap_v && ap.act;
        dp     = ap;
        dp_err = dp_v && is_err(ap);
        dpc    = 0;
        ap_v   = 0;
        if (ops.size() > 0) begin ap = ops.pop_front(); ap_v = 1; end
      end else dpc++;
    end
  endtask

  task automatic prefill(input int k);
    for (int a = 0; a < 64; a++) push(1'b1, 32'(a * 4), 3'd2, $urandom);
    run_ops(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] prior;
    sel = 0;
    m_hsel = 0; m_htrans = 2'b00; m_haddr = '0; m_hwrite = 0; m_hsize = 3'd2;
    m_hburst = '0; m_hprot = '0; m_hwdata = '0; last_rd = '0;
    HRESETn = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_rdy[%0d]", k), 32'(o_rdy[k]), 32'd1);
      chk($sformatf("reset_resp[%0d]", k), 32'(o_resp[k]), 32'd0);
      chk($sformatf("reset_rdata[%0d]", k), o_rdata[k], 32'd0);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;

    // zero wait states
    prefill(0);
    push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    push(1'b0, 32'h10, 3'd2, 32'h0);
    run_ops(0);
    chk("b2b_read", last_rd, 32'hDEADBEEF);
    push(1'b1, 32'h20, 3'd2, 32'h11223344);
    push(1'b1, 32'h22, 3'd0, 32'h00AA0000);
    push(1'b0, 32'h20, 3'd2, 32'h0);
    run_ops(0);
    chk("byte_merge", last_rd, 32'h11AA3344);
    prior = rword(0, 32'h0);
    push(1'b1, 32'h400, 3'd2, 32'hCAFEF00D);
    push(1'b0, 32'h0, 3'd2, 32'h0);
    run_ops(0);
    chk("range_err_nowrite", last_rd, prior);
    push(1'b1, 32'h21, 3'd1, 32'h5A5A5A5A);
    push(1'b1, 32'h20, 3'd3, 32'h77777777);
    push(1'b0, 32'h20, 3'd2, 32'h0);
    run_ops(0);
    chk("misalign_err_nowrite", last_rd, 32'h11AA3344);
    rand_ops(150);
    run_ops(0);

    // three wait states
    prefill(1);
    prior = rword(1, 32'h0);
    push(1'b0, 32'h0, 3'd2, 32'h0);
    run_ops(1);
    chk("ws3_read", last_rd, prior);
    rand_ops(40);
    run_ops(1);

    // five wait states, reset in the middle of a write's wait phase
    prefill(2);
    prior = rword(2, 32'h8);
    sel = 2;
    @(negedge HCLK);
    m_hsel = 1; m_htrans = 2'b10; m_haddr = 32'h8; m_hwrite = 1; m_hsize = 3'd2;
    chk("rst_addr_rdy", 32'(o_rdy[2]), 32'd1);
    @(negedge HCLK);
    m_hsel = 0; m_htrans = 2'b00; m_hwdata = 32'h55;
    chk("rst_wait1_rdy", 32'(o_rdy[2]), 32'd0);
    @(negedge HCLK);
    chk("rst_wait2_rdy", 32'(o_rdy[2]), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_async_rdy", 32'(o_rdy[2]), 32'd1);
    chk("rst_async_resp", 32'(o_resp[2]), 32'd0);
    chk("rst_async_rdata", o_rdata[2], 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    push(1'b0, 32'h8, 3'd2, 32'h0);
    run_ops(2);
    chk("rst_write_dropped", last_rd, prior);
    rand_ops(30);
    run_ops(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
